// File: rtl/rl_pkg.sv
// Shared types for the Q-learning agent loop: datapath widths, controller
// state encoding, and the (s, a, s', terminal) tuple handed to the Q-update block.
package rl_pkg;

   localparam int STATE_W = 6;
   localparam int ACT_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_DECIDE = 3'd3,
      ST_UPDATE = 3'd4,
      ST_CHECK  = 3'd5,
      ST_DONE   = 3'd6
   } ctrl_state_t;

   typedef struct packed {
      logic [STATE_W-1:0] state;
      logic [ACT_W-1:0]   action;
      logic [STATE_W-1:0] next_state;
      logic               terminal;
   } upd_tuple_t;

endpackage

// File: rtl/rl_step_counter.sv
// Step and episode counters for the episode controller, plus the terminal
// (goal or step-limit) and last-episode compares the FSM branches on.
module rl_step_counter
   import rl_pkg::*;
#(
   parameter int STEP_W    = 8,
   parameter int EP_W      = 16,
   parameter int MAX_STEPS = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               step_inc,
   input  logic               episode_inc,
   input  logic [STATE_W-1:0] next_state,
   input  logic [STATE_W-1:0] goal_state,
   input  logic [EP_W-1:0]    num_episodes,
   output logic [STEP_W-1:0]  step_cnt,
   output logic [EP_W-1:0]    episode_cnt,
   output logic               terminal,
   output logic               last_episode
);

   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_STEPS - 1);
   localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
   localparam logic [EP_W-1:0]   EP_ONE    = EP_W'(1);

   logic [STEP_W-1:0] step_cnt_reg;
   logic [EP_W-1:0]   episode_cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         step_cnt_reg    <= '0;
         episode_cnt_reg <= '0;
      end else if (clear) begin
         step_cnt_reg    <= '0;
         episode_cnt_reg <= '0;
      end else if (episode_inc) begin
         episode_cnt_reg <= episode_cnt_reg + EP_ONE;
         step_cnt_reg    <= '0;
      end else if (step_inc) begin
         step_cnt_reg <= step_cnt_reg + STEP_ONE;
      end
   end

   // step_cnt counts completed steps, so the step being decided is the last
   // one allowed when the count already sits at MAX_STEPS-1.
   assign terminal     = (next_state == goal_state) || (step_cnt_reg == STEP_LAST);
   assign last_episode = ((episode_cnt_reg + EP_ONE) == num_episodes);
   assign step_cnt     = step_cnt_reg;
   assign episode_cnt  = episode_cnt_reg;

endmodule

// File: rtl/rl_episode_controller.sv
// Sequencer for the Q-learning agent loop: fetch Q row, let the policy pick,
// hand (s, a, s') to the Q-update block, advance counters until the run ends.
module rl_episode_controller
   import rl_pkg::*;
#(
   parameter int STEP_W    = 8,
   parameter int EP_W      = 16,
   parameter int MAX_STEPS = 64,
   parameter int RD_LAT    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [EP_W-1:0]    num_episodes,
   input  logic [STATE_W-1:0] start_state,
   input  logic [STATE_W-1:0] goal_state,
   output logic               q_rd_en,
   output logic [STATE_W-1:0] q_rd_addr,
   output logic [STATE_W-1:0] pg_state,
   input  logic [ACT_W-1:0]   pg_action,
   input  logic [STATE_W-1:0] pg_next_state,
   output logic               upd_valid,
   input  logic               upd_ready,
   output logic [STATE_W-1:0] upd_state,
   output logic [ACT_W-1:0]   upd_action,
   output logic [STATE_W-1:0] upd_next_state,
   output logic               upd_terminal,
   output logic               busy,
   output logic               done,
   output logic [EP_W-1:0]    episode_cnt,
   output logic [STEP_W-1:0]  step_cnt
);

   localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   ctrl_state_t state_reg, state_next;

   logic               busy_reg;
   logic               done_reg;
   logic [STATE_W-1:0] cur_state_reg;
   logic [STATE_W-1:0] start_lat_reg;
   logic [STATE_W-1:0] goal_lat_reg;
   logic [EP_W-1:0]    num_ep_reg;
   logic [WAIT_W-1:0]  wait_cnt_reg;
   upd_tuple_t         upd_reg;
   logic               upd_valid_reg;

   logic start_accept;
   logic step_inc;
   logic episode_inc;
   logic step_terminal;
   logic last_episode;

   rl_step_counter #(
      .STEP_W    (STEP_W),
      .EP_W      (EP_W),
      .MAX_STEPS (MAX_STEPS)
   ) u_step_counter (
      .clk          (clk),
      .rst          (rst),
      .clear        (start_accept),
      .step_inc     (step_inc),
      .episode_inc  (episode_inc),
      .next_state   (pg_next_state),
      .goal_state   (goal_lat_reg),
      .num_episodes (num_ep_reg),
      .step_cnt     (step_cnt),
      .episode_cnt  (episode_cnt),
      .terminal     (step_terminal),
      .last_episode (last_episode)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      start_accept = 1'b0;
      step_inc     = 1'b0;
      episode_inc  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // busy stays high through the IDLE cycle that follows DONE
            if (start && !busy_reg) begin
               start_accept = 1'b1;
               state_next   = (num_episodes == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH:  state_next = ST_WAIT;
         ST_WAIT: begin
            if (wait_cnt_reg == WAIT_LAST) begin
               state_next = ST_DECIDE;
            end
         end
         ST_DECIDE: state_next = ST_UPDATE;
         ST_UPDATE: begin
            if (upd_ready) begin
               state_next = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (upd_reg.terminal) begin
               episode_inc = 1'b1;
               state_next  = last_episode ? ST_DONE : ST_FETCH;
            end else begin
               step_inc   = 1'b1;
               state_next = ST_FETCH;
            end
         end
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         cur_state_reg <= '0;
         start_lat_reg <= '0;
         goal_lat_reg  <= '0;
         num_ep_reg    <= '0;
         wait_cnt_reg  <= '0;
         upd_reg       <= '0;
         upd_valid_reg <= 1'b0;
      end else begin
         done_reg <= (state_reg == ST_DONE);
         if (start_accept) begin
            busy_reg      <= 1'b1;
            num_ep_reg    <= num_episodes;
            start_lat_reg <= start_state;
            goal_lat_reg  <= goal_state;
            cur_state_reg <= start_state;
         end else if (done_reg) begin
            busy_reg <= 1'b0;
         end
         if (state_reg == ST_FETCH) begin
            wait_cnt_reg <= '0;
         end else if (state_reg == ST_WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + WAIT_ONE;
         end
         if (state_reg == ST_DECIDE) begin
            upd_reg <= '{state:      cur_state_reg,
                         action:     pg_action,
                         next_state: pg_next_state,
                         terminal:   step_terminal};
            upd_valid_reg <= 1'b1;
         end else if (state_reg == ST_UPDATE && upd_ready) begin
            upd_valid_reg <= 1'b0;
         end
         if (state_reg == ST_CHECK) begin
            cur_state_reg <= upd_reg.terminal ? start_lat_reg : upd_reg.next_state;
         end
      end
   end

   assign q_rd_en        = (state_reg == ST_FETCH);
   assign q_rd_addr      = cur_state_reg;
   assign pg_state       = cur_state_reg;
   assign upd_valid      = upd_valid_reg;
   assign upd_state      = upd_reg.state;
   assign upd_action     = upd_reg.action;
   assign upd_next_state = upd_reg.next_state;
   assign upd_terminal   = upd_reg.terminal;
   assign busy           = busy_reg;
   assign done           = done_reg;

endmodule

// File: tb/tb_rl_episode_controller.sv
// Directed bench for rl_episode_controller with MAX_STEPS=4, RD_LAT=3 and a
// trivial policy model (s' = s+1 or s' = s, a = s ^ 4'hA).
module tb_rl_episode_controller;
   import rl_pkg::*;

   localparam int STEP_W    = 8;
   localparam int EP_W      = 16;
   localparam int MAX_STEPS = 4;
   localparam int RD_LAT    = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [EP_W-1:0]    num_episodes = '0;
   logic [STATE_W-1:0] start_state = '0;
   logic [STATE_W-1:0] goal_state = '0;
   logic               q_rd_en;
   logic [STATE_W-1:0] q_rd_addr;
   logic [STATE_W-1:0] pg_state;
   logic [ACT_W-1:0]   pg_action;
   logic [STATE_W-1:0] pg_next_state;
   logic               upd_valid;
   logic               upd_ready = 1'b1;
   logic [STATE_W-1:0] upd_state;
   logic [ACT_W-1:0]   upd_action;
   logic [STATE_W-1:0] upd_next_state;
   logic               upd_terminal;
   logic               busy;
   logic               done;
   logic [EP_W-1:0]    episode_cnt;
   logic [STEP_W-1:0]  step_cnt;
   logic               hold_mode = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign pg_next_state = hold_mode ? pg_state : pg_state + 6'd1;
   assign pg_action     = pg_state[3:0] ^ 4'hA;

   rl_episode_controller #(
      .STEP_W    (STEP_W),
      .EP_W      (EP_W),
      .MAX_STEPS (MAX_STEPS),
      .RD_LAT    (RD_LAT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .num_episodes   (num_episodes),
      .start_state    (start_state),
      .goal_state     (goal_state),
      .q_rd_en        (q_rd_en),
      .q_rd_addr      (q_rd_addr),
      .pg_state       (pg_state),
      .pg_action      (pg_action),
      .pg_next_state  (pg_next_state),
      .upd_valid      (upd_valid),
      .upd_ready      (upd_ready),
      .upd_state      (upd_state),
      .upd_action     (upd_action),
      .upd_next_state (upd_next_state),
      .upd_terminal   (upd_terminal),
      .busy           (busy),
      .done           (done),
      .episode_cnt    (episode_cnt),
      .step_cnt       (step_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until upd_valid is seen; n = cycles taken, -1 on timeout.
   task automatic wait_upd(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (upd_valid === 1'b1) begin
            n = i;
            $display("tuple s=%0d a=%0h s'=%0d term=%0d step=%0d ep=%0d after %0d cycles",
                     upd_state, upd_action, upd_next_state, upd_terminal, step_cnt, episode_cnt, n);
            break;
         end
      end
   endtask

   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (done === 1'b1) begin
            n = i;
            $display("done episodes=%0d after %0d cycles", episode_cnt, n);
            break;
         end
      end
   endtask

   task automatic wait_fetch(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (q_rd_en === 1'b1) begin
            n = i;
            $display("fetch addr=%0d after %0d cycles", q_rd_addr, n);
            break;
         end
      end
   endtask

   task automatic launch(input int eps, input int s0, input int goal);
      num_episodes = EP_W'(eps);
      start_state  = STATE_W'(s0);
      goal_state   = STATE_W'(goal);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({busy, done, q_rd_en, upd_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {busy, done, q_rd_en, upd_valid});
      end
      checks++;
      if ({episode_cnt, step_cnt, pg_state} !== '0) begin
         errors++;
         $display("FAIL reset_counts: got ep=%0d step=%0d pg=%0d expected 0", episode_cnt, step_cnt, pg_state);
      end
   endtask

   task automatic test_basic();
      int n;
      hold_mode = 1'b0;
      upd_ready = 1'b1;
      launch(1, 0, 2);
      checks++;
      if ({q_rd_en, busy, q_rd_addr} !== {1'b1, 1'b1, 6'd0}) begin
         errors++;
         $display("FAIL basic_fetch: got en=%b busy=%b addr=%0d expected 1 1 0", q_rd_en, busy, q_rd_addr);
      end
      wait_upd(n);
      checks++;
      if (n !== 5 || {upd_state, upd_action, upd_next_state, upd_terminal} !== {6'd0, 4'hA, 6'd1, 1'b0}) begin
         errors++;
         $display("FAIL basic_tuple0: got n=%0d s=%0d a=%0h s'=%0d t=%0d expected 5 0 a 1 0",
                  n, upd_state, upd_action, upd_next_state, upd_terminal);
      end
      wait_upd(n);
      checks++;
      if (n !== RD_LAT + 4 || {upd_state, upd_action, upd_next_state, upd_terminal, step_cnt} !==
          {6'd1, 4'hB, 6'd2, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL basic_tuple1: got n=%0d s=%0d a=%0h s'=%0d t=%0d step=%0d expected 7 1 b 2 1 1",
                  n, upd_state, upd_action, upd_next_state, upd_terminal, step_cnt);
      end
      wait_done(n);
      checks++;
      if (n !== 3 || episode_cnt !== 16'd1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_done: got n=%0d ep=%0d busy=%b expected 3 1 1", n, episode_cnt, busy);
      end
      tick();
      checks++;
      if ({busy, done} !== 2'b00 || episode_cnt !== 16'd1) begin
         errors++;
         $display("FAIL basic_idle: got busy=%b done=%b ep=%0d expected 0 0 1", busy, done, episode_cnt);
      end
   endtask

   task automatic test_step_limit();
      int n;
      hold_mode = 1'b1;
      upd_ready = 1'b1;
      launch(2, 5, 9);
      for (int e = 0; e < 2; e++) begin
         for (int k = 0; k < MAX_STEPS; k++) begin
            wait_upd(n);
            checks++;
            if (n < 0 || {upd_state, upd_action, upd_next_state} !== {6'd5, 4'hF, 6'd5} ||
                upd_terminal !== (k == MAX_STEPS - 1) || step_cnt !== 8'(k)) begin
               errors++;
               $display("FAIL limit_tuple e%0d k%0d: got n=%0d s=%0d a=%0h s'=%0d t=%0d step=%0d",
                        e, k, n, upd_state, upd_action, upd_next_state, upd_terminal, step_cnt);
            end
         end
         if (e == 0) begin
            wait_fetch(n);
            checks++;
            if (n !== 2 || q_rd_addr !== 6'd5 || step_cnt !== 8'd0 || episode_cnt !== 16'd1) begin
               errors++;
               $display("FAIL limit_refetch: got n=%0d addr=%0d step=%0d ep=%0d expected 2 5 0 1",
                        n, q_rd_addr, step_cnt, episode_cnt);
            end
         end
      end
      wait_done(n);
      checks++;
      if (n !== 3 || episode_cnt !== 16'd2 || step_cnt !== 8'd0) begin
         errors++;
         $display("FAIL limit_done: got n=%0d ep=%0d step=%0d expected 3 2 0", n, episode_cnt, step_cnt);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int n;
      logic [16:0] held;
      hold_mode = 1'b0;
      upd_ready = 1'b0;
      launch(1, 0, 1);
      wait_upd(n);
      held = {upd_state, upd_action, upd_next_state, upd_terminal};
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (upd_valid !== 1'b1 || q_rd_en !== 1'b0 || {upd_state, upd_action, upd_next_state, upd_terminal} !==
             {6'd0, 4'hA, 6'd1, 1'b1} || held !== {upd_state, upd_action, upd_next_state, upd_terminal}) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: got v=%b en=%b s=%0d a=%0h s'=%0d t=%0d expected 1 0 0 a 1 1",
                     i, upd_valid, q_rd_en, upd_state, upd_action, upd_next_state, upd_terminal);
         end
         tick();
      end
      upd_ready = 1'b1;
      tick();
      checks++;
      if ({upd_valid, q_rd_en} !== 2'b00) begin
         errors++;
         $display("FAIL bp_accept: got v=%b en=%b expected 0 0", upd_valid, q_rd_en);
      end
      wait_done(n);
      checks++;
      if (n !== 2 || episode_cnt !== 16'd1) begin
         errors++;
         $display("FAIL bp_done: got n=%0d ep=%0d expected 2 1", n, episode_cnt);
      end
      tick();
   endtask

   task automatic test_multi_episode();
      int n;
      hold_mode = 1'b0;
      upd_ready = 1'b1;
      launch(3, 0, 1);
      for (int e = 0; e < 3; e++) begin
         if (e > 0) begin
            wait_fetch(n);
            checks++;
            if (n !== 2) begin
               errors++;
               $display("FAIL multi_fetch_gap e%0d: got %0d expected 2", e, n);
            end
         end
         checks++;
         if (q_rd_en !== 1'b1 || q_rd_addr !== 6'd0 || episode_cnt !== 16'(e)) begin
            errors++;
            $display("FAIL multi_fetch e%0d: got en=%b addr=%0d ep=%0d", e, q_rd_en, q_rd_addr, episode_cnt);
         end
         if (e == 0) begin
            // held high with different values for a whole step: must be ignored
            num_episodes = 16'd1;
            start_state  = 6'd7;
            goal_state   = 6'd7;
            start = 1'b1;
         end
         tick();
         checks++;
         if (q_rd_en !== 1'b0 || upd_valid !== 1'b0) begin
            errors++;
            $display("FAIL multi_wait e%0d: got en=%b v=%b expected 0 0", e, q_rd_en, upd_valid);
         end
         wait_upd(n);
         start = 1'b0;
         checks++;
         if (n !== RD_LAT + 1 || {upd_state, upd_next_state, upd_terminal} !== {6'd0, 6'd1, 1'b1}) begin
            errors++;
            $display("FAIL multi_tuple e%0d: got n=%0d s=%0d s'=%0d t=%0d expected 4 0 1 1",
                     e, n, upd_state, upd_next_state, upd_terminal);
         end
      end
      wait_done(n);
      checks++;
      if (n !== 3 || episode_cnt !== 16'd3) begin
         errors++;
         $display("FAIL multi_done: got n=%0d ep=%0d expected 3 3", n, episode_cnt);
      end
      tick();
   endtask

   task automatic test_zero_episodes();
      launch(0, 4, 8);
      checks++;
      if ({q_rd_en, done, busy} !== 3'b001) begin
         errors++;
         $display("FAIL zero_cycle1: got en=%b done=%b busy=%b expected 0 0 1", q_rd_en, done, busy);
      end
      tick();
      checks++;
      if ({q_rd_en, done, busy} !== 3'b011 || episode_cnt !== 16'd0) begin
         errors++;
         $display("FAIL zero_done: got en=%b done=%b busy=%b ep=%0d expected 0 1 1 0",
                  q_rd_en, done, busy, episode_cnt);
      end
      tick();
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL zero_idle: got done=%b busy=%b expected 0 0", done, busy);
      end
   endtask

   task automatic test_reset_mid_update();
      int n;
      hold_mode = 1'b1;
      upd_ready = 1'b0;
      launch(2, 3, 9);
      wait_upd(n);
      checks++;
      if (n !== 5 || upd_valid !== 1'b1 || upd_state !== 6'd3) begin
         errors++;
         $display("FAIL rst_pre: got n=%0d v=%b s=%0d expected 5 1 3", n, upd_valid, upd_state);
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({upd_valid, upd_state, upd_action, upd_next_state, upd_terminal, busy, done, q_rd_en} !== '0 ||
          {pg_state, q_rd_addr, step_cnt, episode_cnt} !== '0) begin
         errors++;
         $display("FAIL rst_mid: got v=%b s=%0d a=%0h s'=%0d t=%b busy=%b done=%b en=%b pg=%0d addr=%0d step=%0d ep=%0d",
                  upd_valid, upd_state, upd_action, upd_next_state, upd_terminal, busy, done, q_rd_en,
                  pg_state, q_rd_addr, step_cnt, episode_cnt);
      end
      rst = 1'b0;
      upd_ready = 1'b1;
      hold_mode = 1'b0;
      tick();
      launch(1, 3, 4);
      checks++;
      if (q_rd_en !== 1'b1 || q_rd_addr !== 6'd3 || pg_state !== 6'd3) begin
         errors++;
         $display("FAIL rst_restart: got en=%b addr=%0d pg=%0d expected 1 3 3", q_rd_en, q_rd_addr, pg_state);
      end
      wait_upd(n);
      checks++;
      if (n !== 5 || {upd_state, upd_action, upd_next_state, upd_terminal} !== {6'd3, 4'h9, 6'd4, 1'b1}) begin
         errors++;
         $display("FAIL rst_tuple: got n=%0d s=%0d a=%0h s'=%0d t=%0d expected 5 3 9 4 1",
                  n, upd_state, upd_action, upd_next_state, upd_terminal);
      end
      wait_done(n);
      checks++;
      if (n !== 3 || episode_cnt !== 16'd1) begin
         errors++;
         $display("FAIL rst_done: got n=%0d ep=%0d expected 3 1", n, episode_cnt);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_step_limit();
      test_backpressure();
      test_multi_episode();
      test_zero_episodes();
      test_reset_mid_update();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
